// File: rtl/b_to_f_sched.sv
// Sequencer and configuration front-end for the b_to_f frequency calculator.
// Issues one computation per accepted field sample and returns a clamped frequency word.
module b_to_f_sched #(
   parameter logic [31:0] A_DEF    = 32'd937546000,
   parameter logic [31:0] B_DEF    = 32'd867339,
   parameter logic [31:0] C_DEF    = 32'd436224,
   parameter logic [7:0]  K_DEF    = 8'd1,
   parameter int unsigned TIMEOUT  = 64,
   parameter logic [31:0] FREQ_MIN = 32'd0,
   parameter logic [31:0] FREQ_MAX = 32'hFFFF_FFFF
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        en_i,
   input  logic [31:0] b_field_i,
   input  logic        b_valid_i,
   input  logic        cfg_wr_i,
   input  logic [2:0]  cfg_addr_i,
   input  logic [31:0] cfg_data_i,
   input  logic        cfg_commit_i,
   input  logic        err_clr_i,
   output logic [31:0] calc_b_field_o,
   output logic [31:0] calc_a_o,
   output logic [31:0] calc_b_o,
   output logic [31:0] calc_c_o,
   output logic [7:0]  calc_k_o,
   output logic        calc_start_o,
   input  logic [31:0] calc_freq_i,
   input  logic        calc_ready_i,
   output logic [31:0] freq_out_o,
   output logic        freq_valid_o,
   output logic        busy_o,
   output logic        timeout_err_o,
   output logic [15:0] overrun_cnt_o
);

   typedef enum logic [1:0] {StIdle, StStart, StWait} state_e;

   state_e      state_q, state_d;
   logic [31:0] wait_cnt_q, wait_cnt_d;
   logic        ready_q;
   logic        pend_q, pend_d;
   logic [31:0] pend_b_q, pend_b_d;
   logic        commit_pend_q, commit_pend_d;
   logic [31:0] sh_a_q, sh_b_q, sh_c_q, sh_a_d, sh_b_d, sh_c_d;
   logic [7:0]  sh_k_q, sh_k_d;
   logic [31:0] act_a_q, act_b_q, act_c_q, act_a_d, act_b_d, act_c_d;
   logic [7:0]  act_k_q, act_k_d;
   logic [31:0] op_bf_q, op_a_q, op_b_q, op_c_q, op_bf_d, op_a_d, op_b_d, op_c_d;
   logic [7:0]  op_k_q, op_k_d;
   logic [31:0] freq_out_q, freq_out_d;
   logic        freq_valid_q, freq_valid_d;
   logic        timeout_err_q, timeout_err_d;
   logic [15:0] ovr_q, ovr_d;

   logic        sample_in, done, expired, timeout_set, ovr_inc, load_op, load_act;
   logic [31:0] op_src, freq_clamped;
   logic [32:0] diff_lo, diff_hi;

   // Unsigned range test via 33-bit borrow so no comparison degenerates at the default limits.
   always_comb begin
      diff_lo = {1'b0, calc_freq_i} - {1'b0, FREQ_MIN};
      diff_hi = {1'b0, FREQ_MAX} - {1'b0, calc_freq_i};
      if (diff_lo[32]) begin
         freq_clamped = FREQ_MIN;
      end else if (diff_hi[32]) begin
         freq_clamped = FREQ_MAX;
      end else begin
         freq_clamped = calc_freq_i;
      end
   end

   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      pend_d        = pend_q;
      pend_b_d      = pend_b_q;
      commit_pend_d = commit_pend_q | cfg_commit_i;
      sh_a_d        = sh_a_q;
      sh_b_d        = sh_b_q;
      sh_c_d        = sh_c_q;
      sh_k_d        = sh_k_q;
      act_a_d       = act_a_q;
      act_b_d       = act_b_q;
      act_c_d       = act_c_q;
      act_k_d       = act_k_q;
      op_bf_d       = op_bf_q;
      op_a_d        = op_a_q;
      op_b_d        = op_b_q;
      op_c_d        = op_c_q;
      op_k_d        = op_k_q;
      freq_out_d    = freq_out_q;
      freq_valid_d  = 1'b0;
      timeout_set   = 1'b0;
      load_op       = 1'b0;
      op_src        = b_field_i;
      sample_in     = en_i & b_valid_i;
      done          = calc_ready_i & ~ready_q;
      expired       = (wait_cnt_q == 32'(TIMEOUT - 1));
      ovr_inc       = 1'b0;

      if (cfg_wr_i) begin
         case (cfg_addr_i)
            3'd0:    sh_a_d = cfg_data_i;
            3'd1:    sh_b_d = cfg_data_i;
            3'd2:    sh_c_d = cfg_data_i;
            3'd3:    sh_k_d = cfg_data_i[7:0];
            default: ;
         endcase
      end

      // Only the newest sample is held while a computation is in flight.
      if (state_q != StIdle && sample_in) begin
         pend_d   = 1'b1;
         pend_b_d = b_field_i;
         ovr_inc  = pend_q;
      end

      unique case (state_q)
         StIdle: begin
            if (sample_in) begin
               state_d = StStart;
               load_op = 1'b1;
            end
         end
         StStart: begin
            state_d    = StWait;
            wait_cnt_d = '0;
         end
         StWait: begin
            wait_cnt_d = wait_cnt_q + 32'd1;
            if (done || expired) begin
               if (done) begin
                  freq_out_d   = freq_clamped;
                  freq_valid_d = 1'b1;
               end else begin
                  timeout_set = 1'b1;
               end
               if (pend_d) begin
                  state_d = StStart;
                  load_op = 1'b1;
                  op_src  = pend_b_d;
                  pend_d  = 1'b0;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      load_act = commit_pend_q && (state_q == StIdle || state_d == StStart);
      if (load_act) begin
         act_a_d       = sh_a_q;
         act_b_d       = sh_b_q;
         act_c_d       = sh_c_q;
         act_k_d       = sh_k_q;
         commit_pend_d = cfg_commit_i;
      end

      // Operands follow the next active set so a same-edge commit takes effect.
      if (load_op) begin
         op_bf_d = op_src;
         op_a_d  = act_a_d;
         op_b_d  = act_b_d;
         op_c_d  = act_c_d;
         op_k_d  = act_k_d;
      end

      if (timeout_set) begin
         timeout_err_d = 1'b1;
      end else if (err_clr_i) begin
         timeout_err_d = 1'b0;
      end else begin
         timeout_err_d = timeout_err_q;
      end

      if (ovr_inc) begin
         ovr_d = (ovr_q == 16'hFFFF) ? ovr_q : ovr_q + 16'd1;
      end else if (err_clr_i) begin
         ovr_d = '0;
      end else begin
         ovr_d = ovr_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= StIdle;
         wait_cnt_q    <= '0;
         ready_q       <= 1'b0;
         pend_q        <= 1'b0;
         pend_b_q      <= '0;
         commit_pend_q <= 1'b0;
         sh_a_q        <= A_DEF;
         sh_b_q        <= B_DEF;
         sh_c_q        <= C_DEF;
         sh_k_q        <= K_DEF;
         act_a_q       <= A_DEF;
         act_b_q       <= B_DEF;
         act_c_q       <= C_DEF;
         act_k_q       <= K_DEF;
         op_bf_q       <= '0;
         op_a_q        <= '0;
         op_b_q        <= '0;
         op_c_q        <= '0;
         op_k_q        <= '0;
         freq_out_q    <= '0;
         freq_valid_q  <= 1'b0;
         timeout_err_q <= 1'b0;
         ovr_q         <= '0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         ready_q       <= calc_ready_i;
         pend_q        <= pend_d;
         pend_b_q      <= pend_b_d;
         commit_pend_q <= commit_pend_d;
         sh_a_q        <= sh_a_d;
         sh_b_q        <= sh_b_d;
         sh_c_q        <= sh_c_d;
         sh_k_q        <= sh_k_d;
         act_a_q       <= act_a_d;
         act_b_q       <= act_b_d;
         act_c_q       <= act_c_d;
         act_k_q       <= act_k_d;
         op_bf_q       <= op_bf_d;
         op_a_q        <= op_a_d;
         op_b_q        <= op_b_d;
         op_c_q        <= op_c_d;
         op_k_q        <= op_k_d;
         freq_out_q    <= freq_out_d;
         freq_valid_q  <= freq_valid_d;
         timeout_err_q <= timeout_err_d;
         ovr_q         <= ovr_d;
      end
   end

   assign calc_b_field_o = op_bf_q;
   assign calc_a_o       = op_a_q;
   assign calc_b_o       = op_b_q;
   assign calc_c_o       = op_c_q;
   assign calc_k_o       = op_k_q;
   assign calc_start_o   = (state_q == StStart);
   assign freq_out_o     = freq_out_q;
   assign freq_valid_o   = freq_valid_q;
   assign busy_o         = (state_q != StIdle);
   assign timeout_err_o  = timeout_err_q;
   assign overrun_cnt_o  = ovr_q;

endmodule
